// File: rtl/axon_spike_scheduler_if.sv
// Spike-in, synapse-SRAM read and row-out handshakes of the axon spike scheduler.
// slave = scheduler side, master = environment (router / SRAM port / neuron core).
interface axon_spike_scheduler_if #(
    parameter int AXON_W         = 8,
    parameter int WORDS_PER_AXON = 8
);
    localparam int ADDR_W = AXON_W + $clog2(WORDS_PER_AXON);

    logic                         spike_valid_i;
    logic [AXON_W-1:0]            spike_axon_i;
    logic                         spike_ready_o;
    logic                         mem_req_o;
    logic [ADDR_W-1:0]            mem_addr_o;
    logic                         mem_gnt_i;
    logic [31:0]                  mem_rdata_i;
    logic                         conn_valid_o;
    logic                         conn_ready_i;
    logic [AXON_W-1:0]            conn_axon_o;
    logic [WORDS_PER_AXON*32-1:0] conn_data_o;

    modport slave (
        input  spike_valid_i, spike_axon_i, mem_gnt_i, mem_rdata_i, conn_ready_i,
        output spike_ready_o, mem_req_o, mem_addr_o, conn_valid_o, conn_axon_o, conn_data_o
    );

    modport master (
        output spike_valid_i, spike_axon_i, mem_gnt_i, mem_rdata_i, conn_ready_i,
        input  spike_ready_o, mem_req_o, mem_addr_o, conn_valid_o, conn_axon_o, conn_data_o
    );
endinterface

// File: rtl/axon_spike_scheduler.sv
// Spike queue + synapse row fetcher: pops axon events, reads 8 SRAM words, presents the row.
// Optional SKIP_EMPTY_ROW_EN: drop all-zero rows and count them on skip_cnt_o.
module axon_spike_scheduler #(
    parameter int AXON_W         = 8,
    parameter int WORDS_PER_AXON = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_AW        = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    axon_spike_scheduler_if.slave bus,
    output logic                  busy_o,
    output logic                  overflow_o
`ifdef SKIP_EMPTY_ROW_EN
    ,
    output logic [15:0]           skip_cnt_o
`endif
);
    localparam int WB = $clog2(WORDS_PER_AXON);
    localparam int CW = WB + 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS_PER_AXON - 1);

    typedef enum logic [1:0] {IDLE, FETCH, OUTPUT} state_t;

    state_t                           state;
    logic [AXON_W-1:0]                fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW:0]                 wr_ptr, rd_ptr;
    logic                             full, empty, push, pop, rdy_en;
    logic [AXON_W-1:0]                fifo_head, axon_q;
    logic [CW-1:0]                    issue_cnt, cap_cnt, issue_nxt;
    logic                             gnt_q, fin, skip, hs;
    logic [WORDS_PER_AXON-1:0][31:0]  row_q, row_nxt;
    logic                             mem_req_q, conn_valid_q, ovf_q;
    logic [AXON_W+WB-1:0]             mem_addr_q;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr == {~rd_ptr[FIFO_AW], rd_ptr[FIFO_AW-1:0]});
    // rdy_en keeps ready low during the reset cycle itself
    assign bus.spike_ready_o = rdy_en & ~full;
    assign push      = bus.spike_valid_i & bus.spike_ready_o;
    assign fifo_head = fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign issue_nxt = issue_cnt + CW'(1);

    assign fin = (state == FETCH) && gnt_q && (cap_cnt == LAST);
    assign hs  = (state == OUTPUT) && conn_valid_q && bus.conn_ready_i;
    // pop on IDLE, or chained straight out of a finished row (no bubble)
    assign pop = ~empty & ((state == IDLE) | hs | skip);

    always_comb begin
        row_nxt = row_q;
        row_nxt[cap_cnt[WB-1:0]] = bus.mem_rdata_i;
    end

`ifdef SKIP_EMPTY_ROW_EN
    assign skip = fin && (row_nxt == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= bus.spike_axon_i;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rdy_en       <= 1'b0;
            ovf_q        <= 1'b0;
            axon_q       <= '0;
            issue_cnt    <= '0;
            cap_cnt      <= '0;
            gnt_q        <= 1'b0;
            row_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            conn_valid_q <= 1'b0;
`ifdef SKIP_EMPTY_ROW_EN
            skip_cnt_o   <= '0;
`endif
        end else begin
            rdy_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
            if (bus.spike_valid_i && full) ovf_q <= 1'b1;

            // SRAM returns data one cycle after each grant
            gnt_q <= mem_req_q & bus.mem_gnt_i;
            if (gnt_q) begin
                row_q   <= row_nxt;
                cap_cnt <= cap_cnt + CW'(1);
            end

            case (state)
                FETCH: begin
                    if (mem_req_q && bus.mem_gnt_i) begin
                        issue_cnt <= issue_nxt;
                        if (issue_cnt == LAST) mem_req_q <= 1'b0;
                        else mem_addr_q <= {axon_q, issue_nxt[WB-1:0]};
                    end
                    if (fin) begin
                        if (skip) begin
                            state <= IDLE;
`ifdef SKIP_EMPTY_ROW_EN
                            if (skip_cnt_o != 16'hFFFF) skip_cnt_o <= skip_cnt_o + 16'd1;
`endif
                        end else begin
                            state        <= OUTPUT;
                            conn_valid_q <= 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (bus.conn_ready_i) begin
                        conn_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: ;
            endcase

            // a pop overrides whatever the case above chose for the next state
            if (pop) begin
                state      <= FETCH;
                axon_q     <= fifo_head;
                issue_cnt  <= '0;
                cap_cnt    <= '0;
                mem_req_q  <= 1'b1;
                mem_addr_q <= {fifo_head, {WB{1'b0}}};
            end
        end
    end

    assign bus.mem_req_o    = mem_req_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.conn_valid_o = conn_valid_q;
    assign bus.conn_axon_o  = axon_q;
    assign bus.conn_data_o  = row_q;
    assign busy_o           = (state != IDLE) | ~empty;
    assign overflow_o       = ovf_q;
endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Directed bench for axon_spike_scheduler: SRAM word at address a holds a (axon 7 reads as zero).
module tb_axon_spike_scheduler;
  typedef logic [255:0] w_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axon_spike_scheduler_if bus ();
  logic busy, overflow;
`ifdef SKIP_EMPTY_ROW_EN
  logic [15:0] skip_cnt;
`endif

  axon_spike_scheduler dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus),
    .busy_o     (busy),
    .overflow_o (overflow)
`ifdef SKIP_EMPTY_ROW_EN
    ,
    .skip_cnt_o (skip_cnt)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input w_t got, input w_t exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return (a[10:3] == 8'd7) ? 32'h0 : {21'b0, a};
  endfunction

  function automatic w_t exp_row(input logic [7:0] ax);
    w_t r;
    logic [2:0] k3;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      k3 = 3'(k);
      r[32*k +: 32] = mem_word({ax, k3});
    end
    return r;
  endfunction

  // SRAM model: data one cycle after a granted request, junk otherwise
  always @(posedge clk)
    bus.mem_rdata_i <= (bus.mem_req_o && bus.mem_gnt_i) ? mem_word(bus.mem_addr_o) : 32'hDEAD_BEEF;

  int gnt_mode = 0;
  always @(posedge clk) begin
    #1;
    bus.mem_gnt_i = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // stall monitor: address must hold while ungranted; log every granted address
  bit mon_en = 0;
  bit prev_stall = 0;
  logic [10:0] prev_addr;
  logic [10:0] issued[$];
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) chk("addr_hold", w_t'(bus.mem_addr_o), w_t'(prev_addr));
      prev_stall = bus.mem_req_o && !bus.mem_gnt_i;
      prev_addr  = bus.mem_addr_o;
      if (bus.mem_req_o && bus.mem_gnt_i) issued.push_back(bus.mem_addr_o);
    end
  end

  task automatic push_one(input logic [7:0] ax);
    @(posedge clk); #1;
    bus.spike_valid_i = 1'b1;
    bus.spike_axon_i  = ax;
    @(posedge clk); #1;
    bus.spike_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (bus.conn_valid_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.conn_valid_o !== 1'b1) chk("conn_valid_timeout", w_t'(bus.conn_valid_o), w_t'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, acc, refused, seen;
    logic [7:0] nx;
    logic [7:0] exp_q[$];
    bus.spike_valid_i = 1'b0;
    bus.spike_axon_i  = '0;
    bus.conn_ready_i  = 1'b1;
    bus.mem_gnt_i     = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", w_t'(bus.spike_ready_o), w_t'(0));
    chk("rst_req",   w_t'(bus.mem_req_o), w_t'(0));
    chk("rst_valid", w_t'(bus.conn_valid_o), w_t'(0));
    chk("rst_busy",  w_t'(busy), w_t'(0));
    chk("rst_ovf",   w_t'(overflow), w_t'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_rst", w_t'(bus.spike_ready_o), w_t'(1));

    // single spike, axon 3, grant always: addresses 24..31, row 9 cycles after pop
    push_one(8'd3);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_addr", w_t'(bus.mem_addr_o), w_t'(24 + i));
      chk("t1_req",  w_t'(bus.mem_req_o), w_t'(1));
    end
    @(negedge clk);
    chk("t1_req_done", w_t'(bus.mem_req_o), w_t'(0));
    chk("t1_not_yet",  w_t'(bus.conn_valid_o), w_t'(0));
    @(negedge clk);
    chk("t1_valid", w_t'(bus.conn_valid_o), w_t'(1));
    chk("t1_axon",  w_t'(bus.conn_axon_o), w_t'(3));
    chk("t1_data",  bus.conn_data_o, exp_row(8'd3));
    @(negedge clk);
    chk("t1_valid_drop", w_t'(bus.conn_valid_o), w_t'(0));
    chk("t1_idle", w_t'(busy), w_t'(0));

    // two spikes queued: second fetch starts right after the first handshake
    @(posedge clk); #1;
    bus.spike_valid_i = 1'b1;
    bus.spike_axon_i  = 8'd5;
    @(posedge clk); #1;
    bus.spike_axon_i  = 8'd6;
    @(posedge clk); #1;
    bus.spike_valid_i = 1'b0;
    wait_valid(40, n);
    chk("t2_axon_a", w_t'(bus.conn_axon_o), w_t'(5));
    chk("t2_data_a", bus.conn_data_o, exp_row(8'd5));
    @(negedge clk);
    chk("t2_chain_valid", w_t'(bus.conn_valid_o), w_t'(0));
    chk("t2_chain_req",   w_t'(bus.mem_req_o), w_t'(1));
    chk("t2_chain_addr",  w_t'(bus.mem_addr_o), w_t'(48));
    wait_valid(40, n);
    chk("t2_gap", w_t'(n), w_t'(9));
    chk("t2_axon_b", w_t'(bus.conn_axon_o), w_t'(6));
    chk("t2_data_b", bus.conn_data_o, exp_row(8'd6));
    @(negedge clk);

    // overflow: consumer stalled, keep offering until refused twice
    bus.conn_ready_i = 1'b0;
    acc = 0; refused = 0; nx = 8'd100;
    @(posedge clk); #1;
    bus.spike_valid_i = 1'b1;
    bus.spike_axon_i  = nx;
    for (int c = 0; c < 40 && refused < 2; c++) begin
      @(negedge clk);
      if (bus.spike_ready_o) begin
        exp_q.push_back(nx);
        acc++;
        nx++;
        @(posedge clk); #1;
        bus.spike_axon_i = nx;
      end else begin
        refused++;
        @(posedge clk); #1;
      end
    end
    bus.spike_valid_i = 1'b0;
    @(negedge clk);
    chk("t3_accepted", w_t'(acc), w_t'(17));
    chk("t3_ready_low", w_t'(bus.spike_ready_o), w_t'(0));
    chk("t3_overflow", w_t'(overflow), w_t'(1));
    bus.conn_ready_i = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wait_valid(40, n);
      chk("t3_order", w_t'(bus.conn_axon_o), w_t'(exp_q[i]));
      chk("t3_data", bus.conn_data_o, exp_row(exp_q[i]));
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("t3_drained", w_t'(busy), w_t'(0));
    chk("t3_ovf_sticky", w_t'(overflow), w_t'(1));

    // random grants: address held through stalls, 8 words in order
    issued.delete();
    prev_stall = 0;
    gnt_mode = 1;
    mon_en = 1;
    push_one(8'd9);
    wait_valid(200, n);
    chk("t4_axon", w_t'(bus.conn_axon_o), w_t'(9));
    chk("t4_data", bus.conn_data_o, exp_row(8'd9));
    chk("t4_nissued", w_t'(issued.size()), w_t'(8));
    for (int k = 0; k < 8; k++)
      chk("t4_seq", w_t'((k < issued.size()) ? issued[k] : 11'h7FF), w_t'(72 + k));
    @(negedge clk);
    mon_en = 0;
    gnt_mode = 0;
    repeat (2) @(posedge clk);

    // reset after the 4th grant abandons the row
    push_one(8'd4);
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t5_ready", w_t'(bus.spike_ready_o), w_t'(0));
    chk("t5_req",   w_t'(bus.mem_req_o), w_t'(0));
    chk("t5_addr",  w_t'(bus.mem_addr_o), w_t'(0));
    chk("t5_valid", w_t'(bus.conn_valid_o), w_t'(0));
    chk("t5_axon",  w_t'(bus.conn_axon_o), w_t'(0));
    chk("t5_data",  bus.conn_data_o, w_t'(0));
    chk("t5_busy",  w_t'(busy), w_t'(0));
    chk("t5_ovf",   w_t'(overflow), w_t'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_ready_back", w_t'(bus.spike_ready_o), w_t'(1));
    push_one(8'd10);
    wait_valid(40, n);
    chk("t5_axon_clean", w_t'(bus.conn_axon_o), w_t'(10));
    chk("t5_data_clean", bus.conn_data_o, exp_row(8'd10));
    @(negedge clk);

    // all-zero row on axon 7
    push_one(8'd7);
`ifdef SKIP_EMPTY_ROW_EN
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.conn_valid_o) seen++;
    end
    chk("t6_no_valid", w_t'(seen), w_t'(0));
    chk("t6_skip_cnt", w_t'(skip_cnt), w_t'(1));
    chk("t6_idle", w_t'(busy), w_t'(0));
`else
    seen = 0;
    wait_valid(40, n);
    chk("t6_axon", w_t'(bus.conn_axon_o), w_t'(7));
    chk("t6_zero_row", bus.conn_data_o, w_t'(0));
    @(negedge clk);
    chk("t6_idle", w_t'(busy), w_t'(seen));
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
